cpsr_flags_unit: RTL and testbench
==================================

// Module: cpsr_flags_unit
// PURPOSE
//  Holds the architectural NZCV flags and drives the Flags bus read by the condition checker.
//  Merges ALU and shifter flag results on S-bit instructions whose condition passed.
//  Also handles direct MSR-style flag writes.
//  Provides a STACK_DEPTH-entry save/restore stack for nested exception entry/return.
// PARAMETERS
//  STACK_DEPTH  4        entries in flag save stack (power of 2, >=2)
//  RESET_FLAGS  4'b0000  Flags value after reset ({C,N,V,Z})
// PORTS
//  clk          in   1       rising-edge clock
//  reset        in   1       synchronous, active-high reset
//  cond_pass    in   1       condition-check result for current instruction
//  s_bit        in   1       instruction requests flag update
//  op_logical   in   1       1 = logical op (C from shifter, V held); 0 = arithmetic
//  alu_n/alu_z/alu_c/alu_v  in  1 each  ALU result flags
//  shift_c      in   1       shifter carry-out
//  msr_we       in   1       direct flag write strobe
//  msr_mask     in   4       per-bit write mask, {C,N,V,Z} order
//  msr_data     in   4       direct flag data, {C,N,V,Z} order
//  save_en      in   1       push current Flags onto stack
//  restore_en   in   1       pop stack top into Flags
//  Flags        out  4       {C,N,V,Z}: [3]=C [2]=N [1]=V [0]=Z
//  stack_level  out  $clog2(STACK_DEPTH)+1  occupied entries
//  stack_full   out  1       stack_level==STACK_DEPTH
//  stack_empty  out  1       stack_level==0
//  stack_err    out  1       push-when-full / pop-when-empty / save+restore collision
//  flags_upd    out  1       1-cycle pulse: Flags was written at the previous edge
// BEHAVIOUR
//  - Reset (sync, high):
//    - Flags=RESET_FLAGS, stack_level=0, stack_empty=1, stack_full=0, stack_err=0, flags_upd=0.
//    - All stack entries are cleared to 0.
//  - All state is registered; a write at edge k is visible on Flags after edge k. No combinational path from inputs to Flags.
//  - Write source priority per cycle: restore (valid pop) > msr_we > ALU update.
//  - ALU update fires when s_bit && cond_pass && !msr_we && !(valid pop):
//    - Arithmetic: {C,N,V,Z} <= {alu_c,alu_n,alu_v,alu_z}.
//    - Logical: N<=alu_n, Z<=alu_z, C<=shift_c, V held.
//  - MSR: Flags[i] <= msr_mask[i] ? msr_data[i] : Flags[i]. Any pending ALU update is discarded that cycle.
//  - Save, when save_en && !restore_en && !full:
//    - Pushes the pre-edge Flags value.
//    - A same-cycle ALU or MSR write still lands in Flags.
//    - level+1.
//  - Restore, when restore_en && !save_en && !empty: Flags <= top entry, level-1.
//  - Push when full: no push, level unchanged, stack_err asserted; other writes proceed.
//  - Pop when empty: no pop, stack_err asserted; MSR/ALU write proceeds as normal.
//  - save_en && restore_en together: neither action occurs; level unchanged; stack_err asserted; MSR/ALU write proceeds.
//  - flags_upd=1 the cycle after any Flags write (ALU, MSR or pop), even if the value is unchanged.
//  - stack_full/stack_empty are decoded from the registered level.
// CONFIGURATION
//  STACK_ERR_STICKY_EN
//   - Defined:
//     - Adds input port err_clr (1 bit).
//     - stack_err is sticky: it stays 1 until reset or err_clr.
//     - err_clr in the same cycle as a new error leaves stack_err=1 (set wins).
//   - Undefined: no err_clr port; stack_err is a 1-cycle pulse per error event.
// TESTING
//  - Reset with RESET_FLAGS=4'b0000, all inputs 0 -> Flags=0000, stack_empty=1, stack_level=0, flags_upd=0.
//  - s_bit=1, cond_pass=1, op_logical=0, alu {n,z,c,v}={1,0,1,1} -> next cycle Flags=4'b1110, flags_upd=1.
//  - Starting from Flags=1110: op_logical=1, alu_n=0, alu_z=1, shift_c=0 -> Flags=0011 (V held at 1).
//  - Same stimulus with cond_pass=0 -> Flags unchanged, flags_upd=0.
//  - msr_we=1, mask=4'b1001, data=4'b0000 while an ALU update is pending -> only C and Z cleared; ALU update ignored.
//  - Stack, STACK_DEPTH=4:
//    - Push Flags 0001,0010,0100,1000 -> stack_full=1.
//    - Fifth push -> stack_err=1, level stays 4.
//    - Four pops -> Flags=1000,0100,0010,0001 in that order.
//    - Fifth pop -> stack_err=1.
//  - save_en=restore_en=1 with level 2 -> level stays 2, stack_err=1.
//    - Sticky build: stack_err holds until err_clr=1.

Source files
------------

// File: rtl/cpsr_flags_unit.sv
// cpsr_flags_unit: architectural NZCV flag register with ALU/shifter merge,
// direct masked (MSR-style) writes and a small save/restore stack used on
// nested exception entry/return.
//
// Flag bit order everywhere is {C,N,V,Z}: [3]=C [2]=N [1]=V [0]=Z.
//
// Build option: define STACK_ERR_STICKY_EN to add the err_clr input and make
// stack_err sticky (set wins over clear). Without it, stack_err is a single
// cycle pulse per error event.
//
// Handshake: there is no valid/ready flow control here. save_en/restore_en
// are single-cycle requests acted on at the next rising edge; a request that
// cannot be honoured (push when full, pop when empty, or both at once) is
// dropped and reported through stack_err.

module cpsr_flags_unit #(
  parameter int         STACK_DEPTH = 4,
  parameter logic [3:0] RESET_FLAGS = 4'b0000
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           cond_pass,
  input  logic                           s_bit,
  input  logic                           op_logical,
  input  logic                           alu_n,
  input  logic                           alu_z,
  input  logic                           alu_c,
  input  logic                           alu_v,
  input  logic                           shift_c,
  input  logic                           msr_we,
  input  logic [3:0]                     msr_mask,
  input  logic [3:0]                     msr_data,
  input  logic                           save_en,
  input  logic                           restore_en,
`ifdef STACK_ERR_STICKY_EN
  input  logic                           err_clr,
`endif
  output logic [3:0]                     Flags,
  output logic [$clog2(STACK_DEPTH):0]   stack_level,
  output logic                           stack_full,
  output logic                           stack_empty,
  output logic                           stack_err,
  output logic                           flags_upd
);

  localparam int IW = $clog2(STACK_DEPTH);
  localparam int LW = IW + 1;
  localparam logic [LW-1:0] FULL_LVL = LW'(STACK_DEPTH);
  localparam logic [LW-1:0] ONE_LVL  = LW'(1);

  logic [3:0]    stack_mem [STACK_DEPTH];
  logic          push_req;
  logic          pop_req;
  logic          do_push;
  logic          do_pop;
  logic          err_evt;
  logic [IW-1:0] push_idx;
  logic [IW-1:0] pop_idx;
  logic [3:0]    flags_nxt;
  logic          flags_wr;

  // Occupancy decode comes straight from the registered level.
  assign stack_full  = (stack_level == FULL_LVL);
  assign stack_empty = (stack_level == '0);

  // The stack grows upward: entry [level] is the next free slot and
  // entry [level-1] is the top.
  assign push_idx = stack_level[IW-1:0];
  assign pop_idx  = IW'(stack_level - ONE_LVL);

  // Classify stack requests: a simultaneous save and restore cancels both.
  always_comb begin
    push_req = save_en & ~restore_en;
    pop_req  = restore_en & ~save_en;
    do_push  = push_req & ~stack_full;
    do_pop   = pop_req & ~stack_empty;
    err_evt  = (save_en & restore_en)
             | (push_req & stack_full)
             | (pop_req & stack_empty);
  end

  // Next flag value: a valid pop beats an MSR write, which beats an ALU update.
  always_comb begin
    flags_nxt = Flags;
    flags_wr  = 1'b0;
    if (do_pop) begin
      flags_nxt = stack_mem[pop_idx];
      flags_wr  = 1'b1;
    end else if (msr_we) begin
      flags_nxt = (msr_mask & msr_data) | (~msr_mask & Flags);
      flags_wr  = 1'b1;
    end else if (s_bit && cond_pass) begin
      if (op_logical) begin
        // Logical ops take carry from the shifter and leave V alone.
        flags_nxt = {shift_c, alu_n, Flags[1], alu_z};
      end else begin
        flags_nxt = {alu_c, alu_n, alu_v, alu_z};
      end
      flags_wr = 1'b1;
    end
  end

  // Flag register and its write-strobe echo.
  always_ff @(posedge clk) begin
    if (reset) begin
      Flags     <= RESET_FLAGS;
      flags_upd <= 1'b0;
    end else begin
      Flags     <= flags_nxt;
      flags_upd <= flags_wr;
    end
  end

  // Stack storage; a push captures the flags as they were before this edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < STACK_DEPTH; i++) begin
        stack_mem[i] <= 4'b0000;
      end
    end else if (do_push) begin
      stack_mem[push_idx] <= Flags;
    end
  end

  // Stack occupancy counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      stack_level <= '0;
    end else if (do_push) begin
      stack_level <= stack_level + ONE_LVL;
    end else if (do_pop) begin
      stack_level <= stack_level - ONE_LVL;
    end
  end

`ifdef STACK_ERR_STICKY_EN
  // Sticky error flag: a new error in the same cycle as err_clr keeps it set.
  always_ff @(posedge clk) begin
    if (reset) begin
      stack_err <= 1'b0;
    end else begin
      stack_err <= err_evt | (stack_err & ~err_clr);
    end
  end
`else
  // Error flag pulses for one cycle after each offending request.
  always_ff @(posedge clk) begin
    if (reset) begin
      stack_err <= 1'b0;
    end else begin
      stack_err <= err_evt;
    end
  end
`endif

endmodule

// File: tb/tb_cpsr_flags_unit.sv
// Testbench for cpsr_flags_unit (default parameters). Directed vector table,
// hand-written stack-error and reset sequences, then randomized traffic
// checked against a queue-based reference model.

module tb_cpsr_flags_unit;

  localparam int DEPTH = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic       cond_pass, s_bit, op_logical;
  logic       alu_n, alu_z, alu_c, alu_v, shift_c;
  logic       msr_we;
  logic [3:0] msr_mask, msr_data;
  logic       save_en, restore_en;
`ifdef STACK_ERR_STICKY_EN
  logic       err_clr;
`endif
  logic [3:0] flags;
  logic [2:0] stack_level;
  logic       stack_full, stack_empty, stack_err, flags_upd;

  cpsr_flags_unit #(.STACK_DEPTH(DEPTH), .RESET_FLAGS(4'b0000)) dut (
    .clk(clk),
    .reset(reset),
    .cond_pass(cond_pass),
    .s_bit(s_bit),
    .op_logical(op_logical),
    .alu_n(alu_n),
    .alu_z(alu_z),
    .alu_c(alu_c),
    .alu_v(alu_v),
    .shift_c(shift_c),
    .msr_we(msr_we),
    .msr_mask(msr_mask),
    .msr_data(msr_data),
    .save_en(save_en),
    .restore_en(restore_en),
`ifdef STACK_ERR_STICKY_EN
    .err_clr(err_clr),
`endif
    .Flags(flags),
    .stack_level(stack_level),
    .stack_full(stack_full),
    .stack_empty(stack_empty),
    .stack_err(stack_err),
    .flags_upd(flags_upd)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_all(input string tag, input logic [3:0] ef, input int el,
                           input logic ee, input logic eu);
    check({tag, " flags"}, int'(flags), int'(ef));
    check({tag, " level"}, int'(stack_level), el);
    check({tag, " full"},  int'(stack_full), int'(el == DEPTH));
    check({tag, " empty"}, int'(stack_empty), int'(el == 0));
    check({tag, " err"},   int'(stack_err), int'(ee));
    check({tag, " upd"},   int'(flags_upd), int'(eu));
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    cond_pass = 0; s_bit = 0; op_logical = 0;
    alu_n = 0; alu_z = 0; alu_c = 0; alu_v = 0; shift_c = 0;
    msr_we = 0; msr_mask = 4'h0; msr_data = 4'h0;
    save_en = 0; restore_en = 0;
`ifdef STACK_ERR_STICKY_EN
    err_clr = 1'b1;
`endif
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic       s, cp, lg, n, z, c, v, sc;
    logic       mw;
    logic [3:0] mm, md;
    logic       sv, rs;
    logic [3:0] ef;
    int         el;
    logic       ee, eu;
  } vec_t;

  function automatic vec_t mk(input logic s, cp, lg, n, z, c, v, sc,
                              input logic mw, input logic [3:0] mm, md,
                              input logic sv, rs, input logic [3:0] ef,
                              input int el, input logic ee, eu);
    vec_t r;
    r.s = s; r.cp = cp; r.lg = lg; r.n = n; r.z = z; r.c = c; r.v = v; r.sc = sc;
    r.mw = mw; r.mm = mm; r.md = md; r.sv = sv; r.rs = rs;
    r.ef = ef; r.el = el; r.ee = ee; r.eu = eu;
    return r;
  endfunction

  vec_t tbl[24];

  // ---------------- reference model ----------------
  logic [3:0] m_flags;
  logic [3:0] m_stk[$];
  logic       m_err, m_upd;

  task automatic model_reset();
    m_flags = 4'b0000;
    m_stk.delete();
    m_err = 1'b0;
    m_upd = 1'b0;
  endtask

  // Computes the post-edge state from the currently driven inputs.
  task automatic model_edge();
    logic [3:0] old_f;
    logic       bad;
    bit         want_push, want_pop, wrote;
    old_f     = m_flags;
    want_push = save_en && !restore_en;
    want_pop  = restore_en && !save_en;
    bad = (save_en && restore_en) ||
          (want_push && m_stk.size() == DEPTH) ||
          (want_pop && m_stk.size() == 0);
    wrote = 1'b1;
    if (want_pop && m_stk.size() > 0) begin
      m_flags = m_stk.pop_back();
    end else if (msr_we) begin
      for (int i = 0; i < 4; i++) if (msr_mask[i]) m_flags[i] = msr_data[i];
    end else if (s_bit && cond_pass) begin
      m_flags[3] = op_logical ? shift_c : alu_c;
      m_flags[2] = alu_n;
      m_flags[1] = op_logical ? old_f[1] : alu_v;
      m_flags[0] = alu_z;
    end else begin
      wrote = 1'b0;
    end
    if (want_push && m_stk.size() < DEPTH) m_stk.push_back(old_f);
    m_upd = wrote;
`ifdef STACK_ERR_STICKY_EN
    m_err = bad || (m_err && !err_clr);
`else
    m_err = bad;
`endif
  endtask

  // ---------------- test ----------------
  initial begin
    tbl[0]  = mk(1,1,0, 1,0,1,1, 0, 0,4'h0,4'h0, 0,0, 4'b1110,0,0,1);
    tbl[1]  = mk(1,1,1, 0,1,0,0, 0, 0,4'h0,4'h0, 0,0, 4'b0011,0,0,1);
    tbl[2]  = mk(1,0,1, 0,1,0,0, 0, 0,4'h0,4'h0, 0,0, 4'b0011,0,0,0);
    tbl[3]  = mk(1,1,0, 1,0,1,1, 0, 1,4'b1001,4'b0000, 0,0, 4'b0010,0,0,1);
    tbl[4]  = mk(0,0,0, 0,0,0,0, 0, 1,4'hF,4'b0001, 0,0, 4'b0001,0,0,1);
    tbl[5]  = mk(0,0,0, 0,0,0,0, 0, 1,4'hF,4'b0010, 1,0, 4'b0010,1,0,1);
    tbl[6]  = mk(0,0,0, 0,0,0,0, 0, 1,4'hF,4'b0100, 1,0, 4'b0100,2,0,1);
    tbl[7]  = mk(0,0,0, 0,0,0,0, 0, 1,4'hF,4'b1000, 1,0, 4'b1000,3,0,1);
    tbl[8]  = mk(0,0,0, 0,0,0,0, 0, 0,4'h0,4'h0, 1,0, 4'b1000,4,0,0);
    tbl[9]  = mk(0,0,0, 0,0,0,0, 0, 0,4'h0,4'h0, 1,0, 4'b1000,4,1,0);
    tbl[10] = mk(0,0,0, 0,0,0,0, 0, 0,4'h0,4'h0, 0,1, 4'b1000,3,0,1);
    tbl[11] = mk(0,0,0, 0,0,0,0, 0, 0,4'h0,4'h0, 0,1, 4'b0100,2,0,1);
    tbl[12] = mk(0,0,0, 0,0,0,0, 0, 0,4'h0,4'h0, 0,1, 4'b0010,1,0,1);
    tbl[13] = mk(0,0,0, 0,0,0,0, 0, 0,4'h0,4'h0, 0,1, 4'b0001,0,0,1);
    tbl[14] = mk(0,0,0, 0,0,0,0, 0, 0,4'h0,4'h0, 0,1, 4'b0001,0,1,0);
    tbl[15] = mk(1,1,0, 1,1,0,0, 0, 0,4'h0,4'h0, 0,1, 4'b0101,0,1,1);
    tbl[16] = mk(0,0,0, 0,0,0,0, 0, 0,4'h0,4'h0, 1,0, 4'b0101,1,0,0);
    tbl[17] = mk(0,0,0, 0,0,0,0, 0, 0,4'h0,4'h0, 1,0, 4'b0101,2,0,0);
    tbl[18] = mk(0,0,0, 0,0,0,0, 0, 0,4'h0,4'h0, 1,1, 4'b0101,2,1,0);
    tbl[19] = mk(0,0,0, 0,0,0,0, 0, 1,4'hF,4'b0110, 1,1, 4'b0110,2,1,1);
    tbl[20] = mk(1,1,0, 0,0,0,0, 0, 0,4'h0,4'h0, 0,1, 4'b0101,1,0,1);
    tbl[21] = mk(0,0,0, 0,0,0,0, 0, 1,4'hF,4'hF, 0,1, 4'b0101,0,0,1);
    tbl[22] = mk(0,0,0, 0,0,0,0, 0, 1,4'b0011,4'hF, 0,1, 4'b0111,0,1,1);
    tbl[23] = mk(1,1,1, 0,0,0,0, 1, 0,4'h0,4'h0, 0,0, 4'b1010,0,0,1);

    // Reset state
    do_reset();
    check_all("reset", 4'b0000, 0, 1'b0, 1'b0);

    // Directed table (err_clr held high in the sticky build, which makes
    // stack_err follow the per-cycle error events exactly)
    foreach (tbl[k]) begin
      s_bit = tbl[k].s; cond_pass = tbl[k].cp; op_logical = tbl[k].lg;
      alu_n = tbl[k].n; alu_z = tbl[k].z; alu_c = tbl[k].c; alu_v = tbl[k].v;
      shift_c = tbl[k].sc;
      msr_we = tbl[k].mw; msr_mask = tbl[k].mm; msr_data = tbl[k].md;
      save_en = tbl[k].sv; restore_en = tbl[k].rs;
      step();
      check_all($sformatf("vec%0d", k), tbl[k].ef, tbl[k].el, tbl[k].ee, tbl[k].eu);
    end

    // Error-flag lifetime after a save/restore collision at level 2
    do_reset();
    save_en = 1; step(); step();
    save_en = 0; step();
    check_all("seq lvl2", 4'b0000, 2, 1'b0, 1'b0);
`ifdef STACK_ERR_STICKY_EN
    err_clr = 1'b0;
`endif
    save_en = 1; restore_en = 1; step();
    check_all("seq collide", 4'b0000, 2, 1'b1, 1'b0);
    save_en = 0; restore_en = 0;
    step();
`ifdef STACK_ERR_STICKY_EN
    check("sticky hold1", int'(stack_err), 1);
    step();
    check("sticky hold2", int'(stack_err), 1);
    restore_en = 1; save_en = 1; err_clr = 1'b1; step();
    check("sticky set wins", int'(stack_err), 1);
    restore_en = 0; save_en = 0; step();
    check("sticky cleared", int'(stack_err), 0);
`else
    check("pulse drops", int'(stack_err), 0);
`endif

    // Reset empties the stack: a pop right after reset must fail
    do_reset();
    check_all("reset2", 4'b0000, 0, 1'b0, 1'b0);
    restore_en = 1; step();
    check_all("pop after reset", 4'b0000, 0, 1'b1, 1'b0);
    restore_en = 0;

    // Randomized traffic against the reference model
    do_reset();
    model_reset();
    for (int t = 0; t < 3000; t++) begin
      int r;
      s_bit      = 1'($urandom_range(0, 1));
      cond_pass  = 1'($urandom_range(0, 1));
      op_logical = 1'($urandom_range(0, 1));
      {alu_n, alu_z, alu_c, alu_v, shift_c} = 5'($urandom_range(0, 31));
      msr_we     = ($urandom_range(0, 3) == 0);
      msr_mask   = 4'($urandom_range(0, 15));
      msr_data   = 4'($urandom_range(0, 15));
      r = $urandom_range(0, 9);
      save_en    = (r <= 3) || (r == 7);
      restore_en = (r >= 4 && r <= 7);
`ifdef STACK_ERR_STICKY_EN
      err_clr    = ($urandom_range(0, 3) == 0);
`endif
      model_edge();
      step();
      check_all("rand", m_flags, m_stk.size(), m_err, m_upd);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
